// File: rtl/instr_ingress_if.sv
// Processor-side instruction handshake bundle.
// Ports: instr (head word), instr_valid (word available), instr_ready (consumer accepts).
// master = ingress block driving words; slave = processor consuming them.
interface instr_ingress_if #(
   parameter int IW = 11
);
   logic [IW-1:0] instr;
   logic          instr_valid;
   logic          instr_ready;

   modport master (
      output instr,
      output instr_valid,
      input  instr_ready
   );

   modport slave (
      input  instr,
      input  instr_valid,
      output instr_ready
   );
endinterface

// File: rtl/instr_ingress.sv
// Purpose: synchronize host pin words into the core clock and queue them in a small FIFO.
// Latency: strobe first sampled high at edge N -> word written and instr_valid high from edge N+2.
// Backpressure: processor throttles with instr_ready; pushes into a full FIFO are dropped and flagged in sticky overflow.
// Ports: clock, reset_n (async active-low); pin_data/pin_strobe (async host pins);
//   proc (instr/instr_valid/instr_ready handshake); fifo_count, full, overflow status; ovf_clear.
module instr_ingress #(
   parameter int IW    = 11,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic [IW-1:0]      pin_data,
   input  logic               pin_strobe,
   instr_ingress_if.master    proc,
   output logic [CW-1:0]      fifo_count,
   output logic               full,
   output logic               overflow,
   input  logic               ovf_clear
);

   localparam int AW = $clog2(DEPTH);

   // Strobe goes through three flops: two for metastability, the third to
   // detect the rising edge. Data needs only two because the host holds it
   // stable around the strobe, so d2 is settled by the time push fires.
   logic          s1, s2, s3;
   logic [IW-1:0] d1, d2;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
         d1 <= '0;
         d2 <= '0;
      end else begin
         s1 <= pin_strobe;
         s2 <= s1;
         s3 <= s2;
         d1 <= pin_data;
         d2 <= d1;
      end
   end

   logic push;
   assign push = s2 & ~s3;

   // FIFO storage; count is kept separately from the pointers so full and
   // empty are unambiguous when the pointers are equal.
   logic [IW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;

   logic pop, do_push, drop;
   assign full     = (fifo_count == CW'(DEPTH));
   assign pop      = proc.instr_valid & proc.instr_ready;
   // A pop in the same cycle frees the slot, so a push at full still lands.
   assign do_push  = push & (~full | pop);
   assign drop     = push & full & ~pop;

   assign proc.instr_valid = (fifo_count != '0);
   // Gated so the head reads as zero while empty (e.g. straight after reset).
   assign proc.instr       = proc.instr_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= d2;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
         // A drop in the same cycle as a clear keeps the flag set.
         if (drop) begin
            overflow <= 1'b1;
         end else if (ovf_clear) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_instr_ingress.sv
// Directed bench for instr_ingress: reset, single word latency, fill/overflow,
// push+pop at full, pointer wrap, and asynchronous mid-operation reset.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_instr_ingress;

   localparam int IW    = 11;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic          clock;
   logic          reset_n;
   logic [IW-1:0] pin_data;
   logic          pin_strobe;
   logic [CW-1:0] fifo_count;
   logic          full;
   logic          overflow;
   logic          ovf_clear;

   int n_checks;
   int n_fail;

   instr_ingress_if #(.IW(IW)) bus ();

   instr_ingress #(.IW(IW), .DEPTH(DEPTH), .CW(CW)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .pin_data   (pin_data),
      .pin_strobe (pin_strobe),
      .proc       (bus.master),
      .fifo_count (fifo_count),
      .full       (full),
      .overflow   (overflow),
      .ovf_clear  (ovf_clear)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Host-side word transfer obeying the pin contract; returns once the word
   // has had time to be written (strobe high 2 cycles, low 2 cycles).
   task automatic send_word(input logic [IW-1:0] w);
      @(negedge clock);
      pin_data = w;
      @(negedge clock);
      pin_strobe = 1'b1;
      repeat (2) @(negedge clock);
      pin_strobe = 1'b0;
      repeat (2) @(negedge clock);
   endtask

   task automatic test_reset;
      reset_n    = 1'b0;
      pin_data   = 11'h7FF;
      pin_strobe = 1'b0;
      ovf_clear  = 1'b0;
      bus.instr_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         pin_strobe = ~pin_strobe;
      end
      pin_strobe = 1'b0;
      @(negedge clock);
      n_checks++;
      if (bus.instr !== 11'h000) begin $display("FAIL reset_instr: got %h expected 000", bus.instr); n_fail++; end
      n_checks++;
      if (bus.instr_valid !== 1'b0) begin $display("FAIL reset_valid: got %b expected 0", bus.instr_valid); n_fail++; end
      n_checks++;
      if (fifo_count !== 3'd0) begin $display("FAIL reset_count: got %0d expected 0", fifo_count); n_fail++; end
      n_checks++;
      if (full !== 1'b0) begin $display("FAIL reset_full: got %b expected 0", full); n_fail++; end
      n_checks++;
      if (overflow !== 1'b0) begin $display("FAIL reset_overflow: got %b expected 0", overflow); n_fail++; end
      reset_n = 1'b1;
      repeat (5) @(negedge clock);
      n_checks++;
      if (fifo_count !== 3'd0) begin $display("FAIL reset_no_push: got %0d expected 0", fifo_count); n_fail++; end
   endtask

   task automatic test_single;
      @(negedge clock);
      pin_data = 11'h5A3;
      @(negedge clock);
      pin_strobe = 1'b1;
      @(negedge clock);            // after edge N
      @(negedge clock);            // after edge N+1
      n_checks++;
      if (bus.instr_valid !== 1'b0) begin $display("FAIL single_early_valid: got %b expected 0", bus.instr_valid); n_fail++; end
      @(negedge clock);            // after edge N+2
      n_checks++;
      if (bus.instr_valid !== 1'b1) begin $display("FAIL single_valid: got %b expected 1", bus.instr_valid); n_fail++; end
      n_checks++;
      if (bus.instr !== 11'h5A3) begin $display("FAIL single_instr: got %h expected 5a3", bus.instr); n_fail++; end
      n_checks++;
      if (fifo_count !== 3'd1) begin $display("FAIL single_count: got %0d expected 1", fifo_count); n_fail++; end
      pin_strobe = 1'b0;
      bus.instr_ready = 1'b1;
      @(negedge clock);
      bus.instr_ready = 1'b0;
      n_checks++;
      if (fifo_count !== 3'd0) begin $display("FAIL single_pop_count: got %0d expected 0", fifo_count); n_fail++; end
      n_checks++;
      if (bus.instr_valid !== 1'b0) begin $display("FAIL single_pop_valid: got %b expected 0", bus.instr_valid); n_fail++; end
      repeat (2) @(negedge clock);
   endtask

   task automatic test_fill;
      logic [IW-1:0] exp_w;
      for (int i = 1; i <= 4; i++) send_word(IW'(i));
      n_checks++;
      if (fifo_count !== 3'd4) begin $display("FAIL fill_count: got %0d expected 4", fifo_count); n_fail++; end
      n_checks++;
      if (full !== 1'b1) begin $display("FAIL fill_full: got %b expected 1", full); n_fail++; end
      n_checks++;
      if (overflow !== 1'b0) begin $display("FAIL fill_no_ovf: got %b expected 0", overflow); n_fail++; end
      send_word(11'd5);
      n_checks++;
      if (overflow !== 1'b1) begin $display("FAIL fill_ovf: got %b expected 1", overflow); n_fail++; end
      n_checks++;
      if (fifo_count !== 3'd4) begin $display("FAIL fill_ovf_count: got %0d expected 4", fifo_count); n_fail++; end
      bus.instr_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         exp_w = IW'(i);
         n_checks++;
         if (bus.instr_valid !== 1'b1 || bus.instr !== exp_w) begin
            $display("FAIL fill_drain_%0d: got valid=%b instr=%h expected valid=1 instr=%h", i, bus.instr_valid, bus.instr, exp_w);
            n_fail++;
         end
         @(negedge clock);
      end
      bus.instr_ready = 1'b0;
      n_checks++;
      if (bus.instr_valid !== 1'b0) begin $display("FAIL fill_drained_valid: got %b expected 0", bus.instr_valid); n_fail++; end
      ovf_clear = 1'b1;
      @(negedge clock);
      ovf_clear = 1'b0;
      n_checks++;
      if (overflow !== 1'b0) begin $display("FAIL fill_ovf_clear: got %b expected 0", overflow); n_fail++; end
   endtask

   task automatic test_simul_full;
      logic [IW-1:0] exp_w;
      for (int i = 0; i < 4; i++) send_word(IW'(11'h010 + i));
      @(negedge clock);
      pin_data = 11'h014;
      @(negedge clock);
      pin_strobe = 1'b1;
      @(negedge clock);            // after edge N
      @(negedge clock);            // after edge N+1
      bus.instr_ready = 1'b1;      // pop coincides with push at edge N+2
      @(negedge clock);
      bus.instr_ready = 1'b0;
      pin_strobe = 1'b0;
      n_checks++;
      if (fifo_count !== 3'd4) begin $display("FAIL simul_count: got %0d expected 4", fifo_count); n_fail++; end
      n_checks++;
      if (overflow !== 1'b0) begin $display("FAIL simul_ovf: got %b expected 0", overflow); n_fail++; end
      repeat (2) @(negedge clock);
      bus.instr_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         exp_w = IW'(11'h010 + i);
         n_checks++;
         if (bus.instr_valid !== 1'b1 || bus.instr !== exp_w) begin
            $display("FAIL simul_drain_%0d: got valid=%b instr=%h expected valid=1 instr=%h", i, bus.instr_valid, bus.instr, exp_w);
            n_fail++;
         end
         @(negedge clock);
      end
      bus.instr_ready = 1'b0;
      n_checks++;
      if (fifo_count !== 3'd0) begin $display("FAIL simul_empty: got %0d expected 0", fifo_count); n_fail++; end
   endtask

   task automatic test_wrap;
      logic [IW-1:0] w;
      for (int i = 0; i < 10; i++) begin
         w = IW'(11'h100 + i * 37);
         send_word(w);
         n_checks++;
         if (fifo_count !== 3'd1 || bus.instr !== w) begin
            $display("FAIL wrap_%0d: got count=%0d instr=%h expected count=1 instr=%h", i, fifo_count, bus.instr, w);
            n_fail++;
         end
         bus.instr_ready = 1'b1;
         @(negedge clock);
         bus.instr_ready = 1'b0;
         n_checks++;
         if (fifo_count !== 3'd0) begin $display("FAIL wrap_pop_%0d: got %0d expected 0", i, fifo_count); n_fail++; end
      end
   endtask

   task automatic test_midop_reset;
      for (int i = 0; i < 3; i++) send_word(IW'(11'h200 + i));
      n_checks++;
      if (fifo_count !== 3'd3) begin $display("FAIL midrst_queued: got %0d expected 3", fifo_count); n_fail++; end
      @(posedge clock);
      #2 reset_n = 1'b0;
      #1;
      n_checks++;
      if (bus.instr_valid !== 1'b0) begin $display("FAIL midrst_valid: got %b expected 0", bus.instr_valid); n_fail++; end
      n_checks++;
      if (fifo_count !== 3'd0) begin $display("FAIL midrst_count: got %0d expected 0", fifo_count); n_fail++; end
      @(negedge clock);
      reset_n = 1'b1;
      repeat (3) @(negedge clock);
      // Refill, then drop a word while ovf_clear is asserted: set must win.
      for (int i = 0; i < 4; i++) send_word(IW'(11'h300 + i));
      @(negedge clock);
      pin_data = 11'h3FF;
      @(negedge clock);
      pin_strobe = 1'b1;
      @(negedge clock);
      @(negedge clock);
      ovf_clear = 1'b1;            // same cycle as the drop at edge N+2
      @(negedge clock);
      ovf_clear = 1'b0;
      pin_strobe = 1'b0;
      n_checks++;
      if (overflow !== 1'b1) begin $display("FAIL midrst_set_wins: got %b expected 1", overflow); n_fail++; end
      ovf_clear = 1'b1;
      @(negedge clock);
      ovf_clear = 1'b0;
      n_checks++;
      if (overflow !== 1'b0) begin $display("FAIL midrst_clear: got %b expected 0", overflow); n_fail++; end
      n_checks++;
      if (fifo_count !== 3'd4 || bus.instr !== 11'h300) begin
         $display("FAIL midrst_refill: got count=%0d instr=%h expected count=4 instr=300", fifo_count, bus.instr);
         n_fail++;
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset;
      test_single;
      test_fill;
      test_simul_full;
      test_wrap;
      test_midop_reset;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
